// File: rtl/cn_minfind_stream_if.sv
// Handshake bundle between the variable-to-check message FIFO, the check-node
// min-finder and the check-to-variable message generator.
interface cn_minfind_stream_if #(
  parameter int DATA_W = 8,
  parameter int DMAX   = 32,
  parameter int IDX_W  = $clog2(DMAX)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-2:0] out_min1;
  logic [DATA_W-2:0] out_min2;
  logic [IDX_W-1:0]  out_idx;
  logic              out_sign;
  logic [IDX_W:0]    out_deg;
  logic              out_err;

  // Upstream/downstream side: drives messages in, consumes results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min1, out_min2, out_idx, out_sign, out_deg, out_err
  );

  // The min-finder itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min1, out_min2, out_idx, out_sign, out_deg, out_err
  );
endinterface

// File: rtl/cn_minfind_stream.sv
// Serial check-node min-finder: one sign-magnitude message per cycle, reports
// min1/min2, position of min1, sign parity and degree for each group.
module cn_minfind_stream #(
  parameter int DATA_W = 8,
  parameter int DMAX   = 32,
  parameter int IDX_W  = $clog2(DMAX)
) (
  input logic                clk,
  input logic                rst,
  cn_minfind_stream_if.slave bus
);
  localparam int MAG_W = DATA_W - 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DMAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [MAG_W-1:0] MAG_ONES = '1;

  typedef enum logic {IDLE, ACCUM} acc_state_e;

  acc_state_e       state_q, state_d;
  logic [MAG_W-1:0] min1_q, min1_d;
  logic [MAG_W-1:0] min2_q, min2_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q;
  logic [MAG_W-1:0] out_min1_q, out_min2_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_sign_q;
  logic [CNT_W-1:0] out_deg_q;
  logic             out_err_q;

  logic             in_ready;
  logic             accept;
  logic             closing;
  logic             force_close;
  logic [MAG_W-1:0] mag;
  logic             sgn;

  assign mag      = bus.in_data[MAG_W-1:0];
  assign sgn      = bus.in_data[DATA_W-1];
  // Input stalls whenever an unconsumed result would otherwise be overwritten.
  assign in_ready = rst & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    min1_d      = min1_q;
    min2_d      = min2_q;
    idx_d       = idx_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    closing     = 1'b0;
    force_close = 1'b0;

    if (accept) begin
      if (state_q == IDLE) begin
        min1_d = mag;
        min2_d = MAG_ONES;
        idx_d  = '0;
        sign_d = sgn;
        cnt_d  = CNT_ONE;
      end else begin
        // Strict less-than: on a tie the earlier beat keeps min1.
        if (mag < min1_q) begin
          min2_d = min1_q;
          min1_d = mag;
          idx_d  = cnt_q[IDX_W-1:0];
        end else if (mag < min2_q) begin
          min2_d = mag;
        end
        sign_d = sign_q ^ sgn;
        cnt_d  = cnt_q + CNT_ONE;
      end
      closing     = bus.in_last | (cnt_d == CNT_MAX);
      force_close = ~bus.in_last & (cnt_d == CNT_MAX);
      state_d     = closing ? IDLE : ACCUM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      // NOTE: accumulator data is reset too; it is a handful of flops and keeps
      // the block free of X after reset.
      min1_q      <= '0;
      min2_q      <= '0;
      idx_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_min1_q  <= '0;
      out_min2_q  <= '0;
      out_idx_q   <= '0;
      out_sign_q  <= 1'b0;
      out_deg_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= closing ? '0 : cnt_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;

      // A new close in the same cycle as a consume reloads and keeps valid high.
      if (closing) begin
        out_valid_q <= 1'b1;
        out_min1_q  <= min1_d;
        out_min2_q  <= min2_d;
        out_idx_q   <= idx_d;
        out_sign_q  <= sign_d;
        out_deg_q   <= cnt_d;
        out_err_q   <= force_close;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_min1  = out_min1_q;
  assign bus.out_min2  = out_min2_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_deg   = out_deg_q;
  assign bus.out_err   = out_err_q;
endmodule
